// File: rtl/disp_pkg.sv
// Shared types and frame-geometry constants for the display VRAM read path.
package disp_pkg;

    localparam int unsigned AXI_DW         = 64;
    localparam int unsigned H_PIXELS_DEF   = 640;
    localparam int unsigned V_LINES_DEF    = 480;
    localparam int unsigned BURST_LEN_DEF  = 64;
    localparam int unsigned FIFO_DEPTH_DEF = 512;

    localparam int unsigned FRAME_BEATS = H_PIXELS_DEF * V_LINES_DEF / 2;
    localparam int unsigned NUM_BURSTS  = FRAME_BEATS / BURST_LEN_DEF;
    localparam int unsigned BURST_BYTES = BURST_LEN_DEF * (AXI_DW / 8);

    typedef enum logic [2:0] {
        IDLE,
        CHKBUF,
        ARWAIT,
        DATA,
        NEXT
    } state_t;

endpackage

// File: rtl/disp_vsync_edge.sv
// Two-flop synchronizer for an active-low sync input plus a one-cycle
// falling-edge pulse; shared by the display blocks.
module disp_vsync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall_pulse
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    // Idle level of the sync is high; resetting to ones avoids a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign fall_pulse = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/disp_vramctrl.sv
// Display VRAM read controller: fetches one frame per VSYNC as fixed-length
// AXI4 read bursts and streams the returned beats into the display FIFO.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int unsigned H_PIXELS   = H_PIXELS_DEF,
    parameter int unsigned V_LINES    = V_LINES_DEF,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              DSP_VSYNC_X,
    input  logic              DISPON,
    input  logic [28:0]       DISPADDR,
    output logic [31:0]       ARADDR,
    output logic [7:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [AXI_DW-1:0] RDATA,
    input  logic              RVALID,
    input  logic              RLAST,
    output logic              RREADY,
    input  logic [9:0]        BUF_WRCNT,
    output logic [AXI_DW-1:0] BUF_WDATA,
    output logic              BUF_WREN,
    output logic              FRAME_BUSY
);

    localparam int unsigned N_BEATS  = H_PIXELS * V_LINES / 2;
    localparam int unsigned N_BURSTS = N_BEATS / BURST_LEN;
    localparam int unsigned B_BYTES  = BURST_LEN * (AXI_DW / 8);
    localparam int unsigned CNT_W    = $clog2(N_BURSTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BURSTS);

    logic vs_start;

    disp_vsync_edge u_vsync_edge (
        .clk        (ACLK),
        .rst_n      (ARST),
        .async_in   (DSP_VSYNC_X),
        .fall_pulse (vs_start)
    );

    state_t           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             busy_q, busy_d;
    logic [31:0]      frame_base;
    logic             buf_fits;
    logic             restart;

    assign frame_base = {3'b000, DISPADDR} & ~(32'(B_BYTES) - 32'd1);
    assign buf_fits   = 32'(BUF_WRCNT) <= (FIFO_DEPTH - BURST_LEN);
    assign restart    = pend_q | vs_start;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        araddr_d  = araddr_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (vs_start && DISPON) begin
                    base_d  = frame_base;
                    cnt_d   = '0;
                    state_d = CHKBUF;
                end
            end
            // No request is in flight here, so an overrun or disable acts at once.
            CHKBUF: begin
                if (!DISPON) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if (restart) begin
                    base_d = frame_base;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end else if (buf_fits) begin
                    arvalid_d = 1'b1;
                    araddr_d  = base_q + 32'(cnt_q) * 32'(B_BYTES);
                    state_d   = ARWAIT;
                end
            end
            ARWAIT: begin
                if (vs_start) pend_d = 1'b1;
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (vs_start) pend_d = 1'b1;
                if (RVALID && RLAST) begin
                    rready_d = 1'b0;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = NEXT;
                end
            end
            NEXT: begin
                pend_d = 1'b0;
                if (restart && DISPON) begin
                    base_d  = frame_base;
                    cnt_d   = '0;
                    state_d = CHKBUF;
                end else if (restart || !DISPON || cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHKBUF;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            state_q   <= IDLE;
            base_q    <= '0;
            araddr_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            araddr_q  <= araddr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
        end
    end

    assign ARADDR     = araddr_q;
    assign ARLEN      = 8'(BURST_LEN - 1);
    assign ARVALID    = arvalid_q;
    assign RREADY     = rready_q;
    assign BUF_WREN   = RVALID & rready_q;
    assign BUF_WDATA  = RDATA;
    assign FRAME_BUSY = busy_q;

endmodule

// File: tb/tb_disp_vramctrl.sv
// Bench for disp_vramctrl with a shortened frame (4 lines) so every scenario
// runs a complete frame; a random-timing AXI slave feeds the DUT.
module tb_disp_vramctrl;

    localparam int unsigned TB_H  = 640;
    localparam int unsigned TB_V  = 4;
    localparam int unsigned TB_BL = 64;
    localparam int unsigned TB_FD = 512;
    localparam int unsigned NB    = TB_H * TB_V / 2 / TB_BL;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        DSP_VSYNC_X;
    logic        DISPON;
    logic [28:0] DISPADDR;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RLAST;
    logic        RREADY;
    logic [9:0]  BUF_WRCNT;
    logic [63:0] BUF_WDATA;
    logic        BUF_WREN;
    logic        FRAME_BUSY;

    int tests = 0;
    int fails = 0;

    int unsigned ar_mode;
    int unsigned rv_rand;
    logic [31:0] ar_log[$];
    int          beats_left;
    int unsigned wren_cnt   = 0;
    int unsigned proto_err  = 0;
    int unsigned data_err   = 0;
    int unsigned arv_cycles = 0;

    disp_vramctrl #(
        .H_PIXELS   (TB_H),
        .V_LINES    (TB_V),
        .BURST_LEN  (TB_BL),
        .FIFO_DEPTH (TB_FD)
    ) dut (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .DISPON      (DISPON),
        .DISPADDR    (DISPADDR),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .RLAST       (RLAST),
        .RREADY      (RREADY),
        .BUF_WRCNT   (BUF_WRCNT),
        .BUF_WDATA   (BUF_WDATA),
        .BUF_WREN    (BUF_WREN),
        .FRAME_BUSY  (FRAME_BUSY)
    );

    always #5 ACLK = ~ACLK;

    // AXI read slave: one burst of TB_BL beats per accepted address.
    always @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            ARREADY    <= 1'b0;
            RVALID     <= 1'b0;
            RLAST      <= 1'b0;
            RDATA      <= '0;
            beats_left = 0;
        end else begin
            if (ARVALID && ARREADY) begin
                ar_log.push_back(ARADDR);
                beats_left = TB_BL;
            end
            if (RVALID && RREADY) beats_left = beats_left - 1;
            case (ar_mode)
                0:       ARREADY <= 1'b1;
                1:       ARREADY <= ($urandom_range(0, 2) != 0);
                default: ARREADY <= 1'b0;
            endcase
            if (!(RVALID && !RREADY)) begin
                if (beats_left > 0 && (rv_rand == 0 || $urandom_range(0, 3) != 0)) begin
                    RVALID <= 1'b1;
                    RDATA  <= {$urandom, $urandom};
                    RLAST  <= (beats_left == 1);
                end else begin
                    RVALID <= 1'b0;
                    RLAST  <= 1'b0;
                end
            end
        end
    end

    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge ACLK) begin
        if (!ARST) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && (ARVALID !== 1'b1 || ARADDR !== prev_addr)) proto_err++;
            prev_pend = (ARVALID === 1'b1) && !ARREADY;
            prev_addr = ARADDR;
            if (ARVALID === 1'b1) arv_cycles++;
            if (ARVALID === 1'b1 && beats_left > 0) proto_err++;
            if (BUF_WREN !== (RVALID && RREADY)) data_err++;
            if (BUF_WREN === 1'b1) begin
                wren_cnt++;
                if (BUF_WDATA !== RDATA) data_err++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_addrs(input int start, input logic [31:0] base, input int n,
                               input string tag);
        for (int k = 0; k < n; k++) begin
            logic [31:0] got;
            got = (start + k < ar_log.size()) ? ar_log[start + k] : 32'hxxxx_xxxx;
            chk($sformatf("%s_%0d", tag, k), got, base + 32'(k) * 32'd512);
        end
    endtask

    task automatic pulse_vs();
        @(negedge ACLK) DSP_VSYNC_X = 1'b0;
        repeat (6) @(negedge ACLK);
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && FRAME_BUSY === 1'b1; i++) @(negedge ACLK);
        chk(tag, FRAME_BUSY, 0);
    endtask

    task automatic wait_beats(input int unsigned w0, input int unsigned n, input string tag);
        for (int i = 0; i < 20000 && (wren_cnt - w0) < n; i++) @(negedge ACLK);
        chk(tag, ((wren_cnt - w0) >= n), 1);
    endtask

    function automatic logic [31:0] aligned(input logic [28:0] a);
        return (32'(a) / 32'd512) * 32'd512;
    endfunction

    initial begin
        int          a0;
        int unsigned w0;
        int unsigned v0;
        logic [28:0] addr_a;
        logic [28:0] addr_b;

        ARST = 1'b0; DSP_VSYNC_X = 1'b1; DISPON = 1'b0; DISPADDR = '0;
        BUF_WRCNT = '0; ar_mode = 0; rv_rand = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_wren", BUF_WREN, 0);
        chk("rst_busy", FRAME_BUSY, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("arlen", ARLEN, TB_BL - 1);
        ARST = 1'b1;
        repeat (3) @(negedge ACLK);

        // Full frame, always-ready slave, plus frame-start latency.
        a0 = ar_log.size(); w0 = wren_cnt;
        DISPON = 1'b1; DISPADDR = 29'h0010_0000;
        @(negedge ACLK) DSP_VSYNC_X = 1'b0;
        @(posedge ACLK); @(posedge ACLK); #1 chk("t1_lat2", FRAME_BUSY, 0);
        @(posedge ACLK); #1 chk("t1_lat3", FRAME_BUSY, 1);
        repeat (4) @(negedge ACLK);
        DSP_VSYNC_X = 1'b1;
        wait_idle(NB * 80 + 200, "t1_idle");
        chk("t1_nbursts", ar_log.size() - a0, NB);
        check_addrs(a0, 32'h0010_0000, NB, "t1_addr");
        chk("t1_beats", wren_cnt - w0, NB * TB_BL);

        // FIFO threshold, then random slave timing and a random base.
        a0 = ar_log.size(); w0 = wren_cnt; v0 = arv_cycles;
        ar_mode = 1; rv_rand = 1;
        BUF_WRCNT = 10'd449; DISPADDR = 29'($urandom);
        pulse_vs();
        repeat (20) @(negedge ACLK);
        chk("t2_hold_noarv", arv_cycles - v0, 0);
        chk("t2_hold_busy", FRAME_BUSY, 1);
        BUF_WRCNT = 10'd448;
        @(posedge ACLK); #1 chk("t2_arv_448", ARVALID, 1);
        @(negedge ACLK) BUF_WRCNT = '0;
        wait_idle(NB * 200 + 400, "t2_idle");
        chk("t2_nbursts", ar_log.size() - a0, NB);
        check_addrs(a0, aligned(DISPADDR), NB, "t2_addr");
        chk("t2_beats", wren_cnt - w0, NB * TB_BL);

        // Alignment and mid-frame DISPADDR change.
        a0 = ar_log.size(); w0 = wren_cnt;
        DISPADDR = 29'h0000_01FF;
        pulse_vs();
        wait_beats(w0, 3 * TB_BL, "t3_progress");
        DISPADDR = 29'($urandom);
        wait_idle(NB * 200 + 400, "t3_idle");
        chk("t3_nbursts", ar_log.size() - a0, NB);
        check_addrs(a0, 32'h0, NB, "t3_addr");

        // DISPON dropped during burst index 5 data.
        ar_mode = 0; rv_rand = 0;
        a0 = ar_log.size(); w0 = wren_cnt;
        DISPADDR = 29'h0040_0000;
        pulse_vs();
        wait_beats(w0, 5 * TB_BL + 10, "t4_progress");
        DISPON = 1'b0;
        wait_idle(400, "t4_idle");
        chk("t4_nbursts", ar_log.size() - a0, 6);
        chk("t4_beats", wren_cnt - w0, 6 * TB_BL);
        check_addrs(a0, 32'h0040_0000, 6, "t4_addr");
        v0 = arv_cycles;
        repeat (100) @(negedge ACLK);
        chk("t4_quiet_arv", arv_cycles - v0, 0);
        chk("t4_quiet_busy", FRAME_BUSY, 0);

        // Frame overrun: second VSYNC during burst index 10.
        DISPON = 1'b1;
        addr_a = 29'h0080_0000; addr_b = 29'h0123_4567;
        a0 = ar_log.size(); w0 = wren_cnt;
        DISPADDR = addr_a;
        pulse_vs();
        wait_beats(w0, 10 * TB_BL + 5, "t5_progress");
        DISPADDR = addr_b;
        pulse_vs();
        wait_idle((NB + 11) * 80 + 400, "t5_idle");
        chk("t5_nbursts", ar_log.size() - a0, 11 + NB);
        check_addrs(a0, aligned(addr_a), 11, "t5_old");
        check_addrs(a0 + 11, aligned(addr_b), NB, "t5_new");
        chk("t5_beats", wren_cnt - w0, (11 + NB) * TB_BL);

        // Asynchronous reset while waiting for ARREADY.
        ar_mode = 2;
        a0 = ar_log.size();
        DISPADDR = 29'h0000_0200;
        pulse_vs();
        for (int i = 0; i < 50 && ARVALID !== 1'b1; i++) @(negedge ACLK);
        chk("t6_arwait", ARVALID, 1);
        repeat (3) @(negedge ACLK);
        #2 ARST = 1'b0;
        #1;
        chk("t6_rst_arvalid", ARVALID, 0);
        chk("t6_rst_busy", FRAME_BUSY, 0);
        chk("t6_rst_rready", RREADY, 0);
        @(negedge ACLK);
        #2 ARST = 1'b1;
        ar_mode = 0;
        v0 = arv_cycles;
        repeat (100) @(negedge ACLK);
        chk("t6_quiet_arv", arv_cycles - v0, 0);
        chk("t6_quiet_ar", ar_log.size() - a0, 0);
        chk("t6_quiet_busy", FRAME_BUSY, 0);
        pulse_vs();
        wait_idle(NB * 80 + 200, "t6_idle");
        chk("t6_nbursts", ar_log.size() - a0, NB);
        check_addrs(a0, 32'h0000_0200, NB, "t6_addr");

        chk("proto_errors", proto_err, 0);
        chk("data_errors", data_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
